serial_pattern_receiver: RTL and testbench

Receives the serial pattern stream produced by the team's 12-bit load-and-shift transmitter and rebuilds the parallel word. Sits at the far end of the serial link, ahead of the hex display decoders. Synchronises the line, finds the start bit, samples each bit at mid-period, checks the stop bit, and presents the word with a one-cycle valid strobe.

---
 rtl/serial_pattern_receiver_pkg.sv | 15 +
 rtl/serial_pattern_receiver_bit_timer.sv | 31 +++
 rtl/serial_pattern_receiver.sv | 133 +++++++++++++
 tb/tb_serial_pattern_receiver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_receiver_pkg.sv
// Shared constants and state encoding for the serial pattern link (receiver and transmitter wrapper).
package serial_pattern_receiver_pkg;

  localparam int unsigned DEFAULT_WIDTH        = 12;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1_000_000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

endpackage

// File: rtl/serial_pattern_receiver_bit_timer.sv
// Loadable down-counter; tick is high whenever the count sits at zero.
module serial_pattern_receiver_bit_timer
  import serial_pattern_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int unsigned CW = $clog2(CLKS_PER_BIT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          tick
);

  logic [CW-1:0] count;

  // tick is kept registered alongside the count so it always equals (count == 0)
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b1;
    end else if (load) begin
      count <= load_value;
      tick  <= (load_value == '0);
    end else if (count != '0) begin
      count <= count - CW'(1);
      tick  <= (count == CW'(1));
    end
  end

endmodule

// File: rtl/serial_pattern_receiver.sv
// Serial frame receiver: synchronises the line, finds the start bit, samples mid-bit and checks the stop bit.
module serial_pattern_receiver
  import serial_pattern_receiver_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_error,
  output logic             busy
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam int unsigned   BW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

  logic             sync1;
  logic             rx;
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
  logic             timer_load;
  logic [CW-1:0]    timer_value;
  logic             shift;
  logic             clear_bits;
  logic             word_good;
  logic             word_bad;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      rx    <= 1'b0;
    end else begin
      sync1 <= serial_in;
      rx    <= sync1;
    end
  end

  serial_pattern_receiver_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) bit_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .tick      (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = FULL_LOAD;
    shift       = 1'b0;
    clear_bits  = 1'b0;
    word_good   = 1'b0;
    word_bad    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx) begin
          state_next  = START;
          timer_value = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (rx) begin
            state_next = DATA;
            clear_bits = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift      = 1'b1;
          timer_load = 1'b1;
          if (bit_cnt == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx) begin
            word_bad   = 1'b1;
            state_next = WAIT_LOW;
          end else begin
            word_good  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_LOW: begin
        if (!rx) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // every state entry restarts the bit timer
    if (state_next != state) timer_load = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid  <= word_good;
      frame_error <= word_bad;
      busy        <= (state_next != IDLE);
      if (clear_bits)  bit_cnt <= '0;
      else if (shift)  bit_cnt <= bit_cnt + BW'(1);
      if (shift)       shreg <= {shreg[WIDTH-2:0], rx};
      if (word_good)   data_out <= shreg;
    end
  end

endmodule

// File: tb/tb_serial_pattern_receiver.sv
// Bench for serial_pattern_receiver: builds a pin/reset waveform, decodes it with a timing-rule model, compares every cycle.
module tb_serial_pattern_receiver;

  localparam int W    = 12;
  localparam int C    = 4;
  localparam int HALF = C / 2;
  localparam int MAXN = 4096;

  logic         clock;
  logic         reset;
  logic         serial_in;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         frame_error;
  logic         busy;

  serial_pattern_receiver #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clock      (clock),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // index k = k-th counted rising edge; pin/rst are the values present at that edge
  logic         pin       [MAXN];
  logic         rst       [MAXN];
  logic         rxm       [MAXN];
  logic         exp_valid [MAXN];
  logic         exp_err   [MAXN];
  logic         exp_busy  [MAXN];
  logic [W-1:0] exp_data  [MAXN];
  int           n;
  int           checks;
  int           passed;

  int           lit_k [$];
  logic         lit_v [$];
  logic         lit_e [$];
  logic [W-1:0] lit_d [$];
  logic         lit_b [$];

  task automatic put_level(input logic v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (n < MAXN) begin
        pin[n] = v;
        rst[n] = 1'b0;
        n++;
      end
    end
  endtask

  task automatic put_frame(input logic [W-1:0] w, input logic stop_v);
    put_level(1'b1, C);
    for (int i = W - 1; i >= 0; i--) put_level(w[i], C);
    put_level(stop_v, C);
  endtask

  task automatic add_lit(input int k, input logic v, input logic e, input logic [W-1:0] d, input logic b);
    lit_k.push_back(k);
    lit_v.push_back(v);
    lit_e.push_back(e);
    lit_d.push_back(d);
    lit_b.push_back(b);
  endtask

  function automatic logic rx_at(input int j);
    return (j < n) ? rxm[j] : 1'b0;
  endfunction

  task automatic set_exp(input int k, input logic v, input logic e, input logic [W-1:0] d, input logic b);
    if (k < n) begin
      exp_valid[k] = v;
      exp_err[k]   = e;
      exp_data[k]  = d;
      exp_busy[k]  = b;
    end
  endtask

  // Decodes the whole waveform from the frame timing rules (E0, mid-bit sample edges, stop edge).
  task automatic build_model();
    int k, e0, s, last, j;
    logic ok, aborted;
    logic [W-1:0] held, w;
    for (int i = 0; i < MAXN; i++) begin
      rxm[i] = 1'b0;
      set_exp(i, 1'b0, 1'b0, '0, 1'b0);
    end
    for (int i = 2; i < n; i++) rxm[i] = (rst[i-1] || rst[i-2]) ? 1'b0 : pin[i-2];
    held = '0;
    k = 0;
    while (k < n) begin
      if (rst[k]) begin
        held = '0;
        set_exp(k, 1'b0, 1'b0, held, 1'b0);
        k++;
      end else if (!rxm[k]) begin
        set_exp(k, 1'b0, 1'b0, held, 1'b0);
        k++;
      end else begin
        e0 = k;
        s = e0 + HALF;
        ok = rx_at(s);
        last = ok ? s + (W + 1) * C : s;
        j = e0;
        aborted = 1'b0;
        while (j < last && j < n) begin
          if (j > e0 && rst[j]) begin
            aborted = 1'b1;
            break;
          end
          set_exp(j, 1'b0, 1'b0, held, 1'b1);
          j++;
        end
        if (aborted || j >= n || rst[last]) begin
          k = j;
        end else if (!ok) begin
          set_exp(last, 1'b0, 1'b0, held, 1'b0);
          k = last + 1;
        end else begin
          w = '0;
          for (int i = 0; i < W; i++) w = {w[W-2:0], rx_at(s + (i + 1) * C)};
          k = last + 1;
          if (!rx_at(last)) begin
            held = w;
            set_exp(last, 1'b1, 1'b0, held, 1'b0);
          end else begin
            set_exp(last, 1'b0, 1'b1, held, 1'b1);
            while (k < n && !rst[k] && rxm[k]) begin
              set_exp(k, 1'b0, 1'b0, held, 1'b1);
              k++;
            end
            if (k < n && !rst[k]) begin
              set_exp(k, 1'b0, 1'b0, held, 1'b0);
              k++;
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input int k, input logic [W-1:0] act, input logic [W-1:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s at cycle %0d: got %h, want %h", name, k, act, want);
  endtask

  initial begin
    int p2, p3, p4, p5, p6, p7, start, kind;
    logic [W-1:0] word;
    checks    = 0;
    passed    = 0;
    n         = 0;
    reset     = 1'b1;
    serial_in = 1'b0;

    // reset held two cycles with the line high
    put_level(1'b1, 2);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    put_level(1'b0, 10);
    add_lit(1, 1'b0, 1'b0, 12'h000, 1'b0);
    add_lit(2, 1'b0, 1'b0, 12'h000, 1'b0);

    p2 = n;
    put_frame(12'hA5C, 1'b0);
    put_level(1'b0, 10);
    add_lit(p2 + 3,  1'b0, 1'b0, 12'h000, 1'b1);
    add_lit(p2 + 55, 1'b0, 1'b0, 12'h000, 1'b1);
    add_lit(p2 + 56, 1'b1, 1'b0, 12'hA5C, 1'b0);
    add_lit(p2 + 57, 1'b0, 1'b0, 12'hA5C, 1'b0);

    p3 = n;
    put_frame(12'hFFF, 1'b0);
    put_frame(12'h001, 1'b0);
    put_level(1'b0, 10);
    add_lit(p3 + 56,  1'b1, 1'b0, 12'hFFF, 1'b0);
    add_lit(p3 + 111, 1'b0, 1'b0, 12'hFFF, 1'b1);
    add_lit(p3 + 112, 1'b1, 1'b0, 12'h001, 1'b0);

    p4 = n;
    put_frame(12'h123, 1'b1);
    put_level(1'b1, 20);
    put_level(1'b0, 10);
    add_lit(p4 + 56, 1'b0, 1'b1, 12'h001, 1'b1);
    add_lit(p4 + 70, 1'b0, 1'b0, 12'h001, 1'b1);
    add_lit(p4 + 77, 1'b0, 1'b0, 12'h001, 1'b1);
    add_lit(p4 + 78, 1'b0, 1'b0, 12'h001, 1'b0);

    p5 = n;
    put_level(1'b1, 1);
    put_level(1'b0, 10);
    add_lit(p5 + 3, 1'b0, 1'b0, 12'h001, 1'b1);
    add_lit(p5 + 4, 1'b0, 1'b0, 12'h001, 1'b0);
    add_lit(p5 + 5, 1'b0, 1'b0, 12'h001, 1'b0);

    p6 = n;
    put_frame(12'h5A5, 1'b0);
    rst[p6 + 30] = 1'b1;
    for (int i = p6 + 31; i < p6 + 56; i++) pin[i] = 1'b0;
    put_level(1'b0, 8);
    p7 = n;
    put_frame(12'h3C3, 1'b0);
    put_level(1'b0, 10);
    add_lit(p6 + 29, 1'b0, 1'b0, 12'h001, 1'b1);
    add_lit(p6 + 30, 1'b0, 1'b0, 12'h000, 1'b0);
    add_lit(p6 + 31, 1'b0, 1'b0, 12'h000, 1'b0);
    add_lit(p7 + 56, 1'b1, 1'b0, 12'h3C3, 1'b0);

    // randomized traffic: good frames, bad stops, glitches, mid-frame resets, random gaps
    for (int r = 0; r < 30; r++) begin
      kind = int'($urandom_range(0, 9));
      word = W'($urandom);
      if (kind == 0) begin
        put_level(1'b1, int'($urandom_range(1, 3)));
      end else if (kind == 1) begin
        put_frame(word, 1'b1);
        put_level(1'b1, int'($urandom_range(0, 12)));
      end else if (kind == 2) begin
        start = n;
        put_frame(word, 1'b0);
        rst[start + int'($urandom_range(3, 50))] = 1'b1;
      end else begin
        put_frame(word, 1'b0);
      end
      put_level(1'b0, int'($urandom_range(0, 6)));
    end
    put_level(1'b0, 120);

    build_model();

    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      serial_in = pin[k];
      reset     = rst[k];
      @(posedge clock);
      #1;
      check("data_out",    k, data_out,       exp_data[k]);
      check("data_valid",  k, W'(data_valid), W'(exp_valid[k]));
      check("frame_error", k, W'(frame_error), W'(exp_err[k]));
      check("busy",        k, W'(busy),       W'(exp_busy[k]));
      for (int i = 0; i < lit_k.size(); i++) begin
        if (lit_k[i] == k) begin
          check("lit_data_out",    k, data_out,        lit_d[i]);
          check("lit_data_valid",  k, W'(data_valid),  W'(lit_v[i]));
          check("lit_frame_error", k, W'(frame_error), W'(lit_e[i]));
          check("lit_busy",        k, W'(busy),        W'(lit_b[i]));
          check("model_data_out",  k, exp_data[k],     lit_d[i]);
          check("model_valid",     k, W'(exp_valid[k]), W'(lit_v[i]));
          check("model_error",     k, W'(exp_err[k]),   W'(lit_e[i]));
          check("model_busy",      k, W'(exp_busy[k]),  W'(lit_b[i]));
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
